up_memctl: RTL and testbench

Memory-side bus controller for the 8-bit microprocessor. It sits between the datapath's `data_out` and its `data_in` and is sequenced by the control unit. It latches an address and write data from the datapath and runs one single-beat read or write on an external synchronous memory, with wait states. It returns read data to the datapath and signals completion with a one-cycle `done` pulse.

---
 rtl/up_pkg.sv | 23 ++
 rtl/up_memctl_timer.sv | 28 ++
 rtl/up_memctl.sv | 131 +++++++++++++
 tb/tb_up_memctl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/up_pkg.sv
// rtl/up_pkg.sv - shared types and constants for the up_memctl memory-side bus controller
package up_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam int DEF_TIMEOUT_CYCLES = 15;

  // Datapath ops the control unit uses to put an address on dp_data; any
  // other op falls through to the default, which passes data_in straight on.
  localparam logic [4:0] OP_PC_CODE_ADDR = 5'b10010;
  localparam logic [4:0] OP_PC_DATA_ADDR = 5'b10011;
  localparam logic [4:0] OP_DEFAULT      = 5'b00000;

  function automatic logic is_addr_op(input logic [4:0] op);
    return (op == OP_PC_CODE_ADDR) || (op == OP_PC_DATA_ADDR);
  endfunction

endpackage

// File: rtl/up_memctl_timer.sv
// rtl/up_memctl_timer.sv - loadable down-counter with terminal count for the access timeout
module up_memctl_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Saturates at zero so tc stays asserted until the next load.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/up_memctl.sv
// rtl/up_memctl.sv - single-beat memory bus controller; timeout/ERR built only with UP_MEMCTL_TIMEOUT_EN
module up_memctl
  import up_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [7:0] dp_data,
  input  logic       addr_we,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       addr_inc,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rd_data,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_cs,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("up_memctl: TIMEOUT_CYCLES must be 1..255");
  end

  state_t     state, state_nxt;
  logic [7:0] addr_q, wdata_q, rdata_q;
  logic       wr_q, inc_q;
  logic       accept;
  logic       timeout;

  assign accept = (state == ST_IDLE) && (rd_req || wr_req);

`ifdef UP_MEMCTL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic err_q;

  // Loaded with N-1 so terminal count coincides with the N-th ACCESS cycle.
  up_memctl_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .Rst      (Rst),
    .load     (accept),
    .load_val (TW'(TIMEOUT_CYCLES - 1)),
    .en       (state == ST_ACCESS),
    .tc       (timeout)
  );

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((state == ST_ACCESS) && timeout && !mem_ready) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        // mem_ready wins over a coincident timeout
        if (mem_ready) begin
          state_nxt = ST_DONE;
        end else if (timeout) begin
`ifdef UP_MEMCTL_TIMEOUT_EN
          state_nxt = ST_ERR;
`else
          state_nxt = ST_ACCESS;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      wr_q    <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (addr_we) addr_q <= dp_data;
        if (accept) begin
          wr_q  <= wr_req;
          inc_q <= addr_inc;
          if (wr_req) wdata_q <= dp_data;
        end
      end
      if ((state == ST_ACCESS) && mem_ready && !wr_q) begin
        rdata_q <= mem_rdata;
      end
      if ((state == ST_DONE) && inc_q) begin
        addr_q <= addr_q + 8'd1;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) || (state == ST_ERR);
  assign mem_cs    = (state == ST_ACCESS);
  assign mem_we    = mem_cs && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rd_data   = rdata_q;

endmodule

// File: tb/tb_up_memctl.sv
// tb/tb_up_memctl.sv - randomized transaction-level scoreboard bench for up_memctl
module tb_up_memctl;

`ifdef UP_MEMCTL_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 15;
`endif

  logic       clk = 1'b0;
  logic       Rst;
  logic [7:0] dp_data;
  logic       addr_we, rd_req, wr_req, addr_inc;
  logic       busy, done, err, mem_cs, mem_we;
  logic [7:0] rd_data, mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;

  up_memctl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .dp_data   (dp_data),
    .addr_we   (addr_we),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .addr_inc  (addr_inc),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_data   (rd_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected outputs for the current cycle
  logic       exp_valid = 1'b0;
  logic       e_busy, e_done, e_err, e_cs, e_we;
  logic [7:0] e_addr, e_wdata, e_rd;

  // transaction-level model of the controller's visible registers
  logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_rd = 8'h00;
  logic       m_err = 1'b0;

  // one-shot literal expectation
  logic       lit_en = 1'b0;
  string      lit_name;
  int         lit_sel, lit_base;
  logic [7:0] lit_val;

  int         done_cnt = 0, we_cnt = 0;
  logic [7:0] act;

  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("busy",      {7'd0, busy},   {7'd0, e_busy});
      chk("done",      {7'd0, done},   {7'd0, e_done});
      chk("err",       {7'd0, err},    {7'd0, e_err});
      chk("mem_cs",    {7'd0, mem_cs}, {7'd0, e_cs});
      chk("mem_we",    {7'd0, mem_we}, {7'd0, e_we});
      chk("mem_addr",  mem_addr,  e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("rd_data",   rd_data,   e_rd);
    end
    if (lit_en) begin
      case (lit_sel)
        0:       act = rd_data;
        1:       act = mem_addr;
        2:       act = mem_wdata;
        3:       act = {7'd0, err};
        4:       act = 8'(done_cnt - lit_base);
        default: act = 8'(we_cnt - lit_base);
      endcase
      chk(lit_name, act, lit_val);
    end
    if (done) done_cnt++;
    if (mem_cs && mem_we) we_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic b, input logic d, input logic cs, input logic we);
    exp_valid = 1'b1;
    e_busy = b; e_done = d; e_cs = cs; e_we = we;
    e_addr = m_addr; e_wdata = m_wdata; e_rd = m_rd; e_err = m_err;
  endtask

  task automatic idle_cycle(input logic awe, input logic [7:0] d);
    rd_req = 1'b0; wr_req = 1'b0; addr_inc = 1'(1'($urandom));
    addr_we = awe; dp_data = d;
    mem_ready = 1'($urandom); mem_rdata = 8'($urandom);
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if (awe) m_addr = d;
  endtask

  task automatic pin(input string nm, input int sel, input logic [7:0] v, input int base);
    lit_name = nm; lit_sel = sel; lit_val = v; lit_base = base; lit_en = 1'b1;
    idle_cycle(1'b0, 8'h00);
    lit_en = 1'b0;
  endtask

  task automatic txn(input logic rd, input logic wr, input logic awe, input logic inc,
                     input logic [7:0] d, input int waits, input logic [7:0] rdat,
                     input logic poke);
    logic is_wr, timed_out;
    int   n_acc;
    is_wr = wr;
    rd_req = rd; wr_req = wr; addr_we = awe; addr_inc = inc; dp_data = d;
    mem_ready = 1'($urandom); mem_rdata = 8'($urandom);
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if (awe) m_addr = d;
    if (wr) m_wdata = d;
    m_err = 1'b0;
`ifdef UP_MEMCTL_TIMEOUT_EN
    timed_out = (waits >= TO);
`else
    timed_out = 1'b0;
`endif
    n_acc = timed_out ? TO : waits + 1;
    for (int k = 1; k <= n_acc; k++) begin
      rd_req   = poke ? 1'($urandom) : 1'b0;
      wr_req   = poke ? 1'($urandom) : 1'b0;
      addr_we  = 1'($urandom);
      dp_data  = 8'($urandom);
      addr_inc = 1'($urandom);
      mem_ready = !timed_out && (k == n_acc);
      mem_rdata = (k == n_acc) ? rdat : 8'($urandom);
      set_exp(1'b1, 1'b0, 1'b1, is_wr);
      tick();
      if (mem_ready && !is_wr) m_rd = rdat;
    end
    if (timed_out) m_err = 1'b1;
    rd_req = poke; wr_req = 1'b0; addr_we = 1'b1; dp_data = 8'($urandom);
    mem_ready = 1'($urandom);
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    if (inc && !timed_out) m_addr = m_addr + 8'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    Rst = 1'b1; dp_data = 8'h00; addr_we = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    addr_inc = 1'b0; mem_rdata = 8'h00; mem_ready = 1'b0;
    tick();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    Rst = 1'b0;
    pin("reset_rd_data", 0, 8'h00, 0);
    pin("reset_mem_addr", 1, 8'h00, 0);
    pin("reset_mem_wdata", 2, 8'h00, 0);
    pin("reset_err", 3, 8'h00, 0);

    // single read
    idle_cycle(1'b1, 8'h3C);
    base = done_cnt;
    txn(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'hA5, 1'b0);
    pin("read_rd_data", 0, 8'hA5, 0);
    pin("read_addr", 1, 8'h3C, 0);
    pin("read_done_count", 4, 8'd1, base);

    // write with post-increment wrapping FF -> 00, three wait states
    base = we_cnt;
    txn(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 3, 8'h00, 1'b0);
    pin("write_we_cycles", 5, 8'd4, base);
    pin("write_wdata", 2, 8'hFF, 0);
    pin("write_wrap_addr", 1, 8'h00, 0);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1, 8'h17, 1'b0);
    pin("wrap_read_data", 0, 8'h17, 0);

    // simultaneous requests, then requests while busy
    base = done_cnt;
    txn(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 2, 8'h00, 1'b1);
    pin("simul_done_count", 4, 8'd1, base);
    pin("simul_wdata", 2, 8'h5A, 0);
    pin("simul_rd_kept", 0, 8'h17, 0);

`ifdef UP_MEMCTL_TIMEOUT_EN
    txn(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 10, 8'h00, 1'b0);
    pin("timeout_err", 3, 8'h01, 0);
    pin("timeout_rd_kept", 0, 8'h17, 0);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h99, 1'b0);
    pin("timeout_err_cleared", 3, 8'h00, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      logic w, r;
      int gap;
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle(1'($urandom), 8'($urandom));
      txn(r, w, 1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 6),
          8'($urandom), 1'($urandom));
    end

    // reset in the middle of an access
    base = done_cnt;
    rd_req = 1'b1; wr_req = 1'b0; addr_we = 1'b1; dp_data = 8'hC3; addr_inc = 1'b1;
    mem_ready = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rd_req = 1'b0; addr_we = 1'b0;
    m_addr = 8'h00; m_wdata = 8'h00; m_rd = 8'h00; m_err = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    #2 Rst = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    tick();
    Rst = 1'b0;
    pin("rst_mid_done_count", 4, 8'd0, base);
    pin("rst_mid_addr", 1, 8'h00, 0);
    txn(1'b1, 1'b0, 1'b1, 1'b0, 8'h42, 1, 8'h6E, 1'b0);
    pin("after_rst_read", 0, 8'h6E, 0);

    exp_valid = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
